bist_response_analyzer: RTL and testbench

Receiving end of the multiplier BIST path. It observes the radix_4 result/ready stream and detects each completed multiplication on the rising edge of ready_in. Each detected result is compacted into a 16-bit MISR signature, and the block counts the compacted patterns. After N_PATTERNS results it compares the signature against a golden constant and reports pass/fail, so the BIST wrapper can expose a single verdict instead of a raw signature.

---
 rtl/bist_response_analyzer.sv | 91 +++++++++
 tb/tb_bist_response_analyzer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: compacts each rising-edge-qualified multiplier result
// into a MISR signature and reports a pass/fail verdict after N_PATTERNS results.
module bist_response_analyzer #(
   parameter int               WIDTH      = 16,
   parameter int               N_PATTERNS = 64,
   parameter logic [WIDTH-1:0] SEED       = 16'h0000,
   parameter logic [WIDTH-1:0] POLY       = 16'h002D,
   parameter logic [WIDTH-1:0] GOLDEN     = 16'h0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] result_in,
   input  logic             ready_in,
   output logic [WIDTH-1:0] signature,
   output logic [7:0]       count,
   output logic             busy,
   output logic             done,
   output logic             pass
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [7:0] LAST_CNT = 8'(N_PATTERNS - 1);

   state_t           state, state_nx;
   logic             ready_d;
   logic             accept;
   logic             last;
   logic [WIDTH-1:0] sig_next;

   assign accept   = (state == RUN) && ready_in && !ready_d;
   assign last     = (count == LAST_CNT);
   assign sig_next = {signature[WIDTH-2:0], 1'b0} ^ (signature[WIDTH-1] ? POLY : '0) ^ result_in;

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: if (start) state_nx = RUN;
         RUN: begin
            busy = 1'b1;
            if (accept && last) state_nx = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nx = RUN;
         end
         default: state_nx = IDLE;
      endcase
      if (abort) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         ready_d   <= 1'b0;
         signature <= SEED;
         count     <= 8'd0;
         pass      <= 1'b0;
      end else begin
         state   <= state_nx;
         ready_d <= ready_in;
         // abort keeps signature and count so a stopped session can be inspected
         if (abort) begin
            pass <= 1'b0;
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (start) begin
                     signature <= SEED;
                     count     <= 8'd0;
                     pass      <= 1'b0;
                  end
               end
               RUN: begin
                  if (accept) begin
                     signature <= sig_next;
                     count     <= count + 8'd1;
                     if (last) pass <= (sig_next == GOLDEN);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Bench: two analyzers (2-pattern and 64-pattern sessions) checked every cycle
// against a session-history model, plus hand-computed literal expectations.
module tb_bist_response_analyzer;

   function automatic logic [15:0] misr_step(logic [15:0] s, logic [15:0] r);
      return {s[14:0], 1'b0} ^ (s[15] ? 16'h002D : 16'h0000) ^ r;
   endfunction

   function automatic logic [15:0] lfsr_next(logic [15:0] x);
      return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [15:0] gold_calc();
      logic [15:0] s, x;
      s = 16'h0000;
      x = 16'hACE1;
      for (int k = 0; k < 64; k++) begin
         s = misr_step(s, x);
         x = lfsr_next(x);
      end
      return s;
   endfunction

   localparam logic [15:0] GOLD_B = gold_calc();

   logic        clk, reset, start_a, start_b, abort, ready_in;
   logic [15:0] result_in;
   logic [15:0] sig_a, sig_b;
   logic [7:0]  count_a, count_b;
   logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;

   int nchk = 0;
   int nerr = 0;

   bist_response_analyzer #(.WIDTH(16), .N_PATTERNS(2), .SEED(16'h0000),
      .POLY(16'h002D), .GOLDEN(16'h0000)) u_a (
      .clk(clk), .reset(reset), .start(start_a), .abort(abort),
      .result_in(result_in), .ready_in(ready_in), .signature(sig_a),
      .count(count_a), .busy(busy_a), .done(done_a), .pass(pass_a));

   bist_response_analyzer #(.WIDTH(16), .N_PATTERNS(64), .SEED(16'h0000),
      .POLY(16'h002D), .GOLDEN(GOLD_B)) u_b (
      .clk(clk), .reset(reset), .start(start_b), .abort(abort),
      .result_in(result_in), .ready_in(ready_in), .signature(sig_b),
      .count(count_b), .busy(busy_b), .done(done_b), .pass(pass_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: a session is the list of accepted results; signature is their fold.
   int          np [2] = '{2, 64};
   logic [15:0] gd [2];
   logic [15:0] hist [2][256];
   int          cnt [2] = '{0, 0};
   bit          run [2] = '{0, 0};
   bit          mdone [2] = '{0, 0};
   bit          mpass [2] = '{0, 0};
   bit          prev [2] = '{0, 0};

   initial begin
      gd[0] = 16'h0000;
      gd[1] = GOLD_B;
   end

   function automatic logic [15:0] fold(int i, int n);
      logic [15:0] s;
      s = 16'h0000;
      for (int k = 0; k < n; k++) s = misr_step(s, hist[i][k]);
      return s;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            cnt[i] = 0; run[i] = 0; mdone[i] = 0; mpass[i] = 0; prev[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            bit st, acc;
            st  = (i == 0) ? start_a : start_b;
            acc = run[i] && ready_in && !prev[i];
            if (abort) begin
               run[i] = 0; mdone[i] = 0; mpass[i] = 0;
            end else if (!run[i] && st) begin
               run[i] = 1; mdone[i] = 0; cnt[i] = 0; mpass[i] = 0;
            end else if (acc) begin
               hist[i][cnt[i]] = result_in;
               cnt[i]++;
               if (cnt[i] == np[i]) begin
                  run[i]   = 0;
                  mdone[i] = 1;
                  mpass[i] = (fold(i, cnt[i]) == gd[i]);
               end
            end
            prev[i] = ready_in;
         end
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #2;
      chk("a.signature", {16'h0, sig_a}, {16'h0, fold(0, cnt[0])});
      chk("a.count", {24'h0, count_a}, cnt[0]);
      chk("a.busy", {31'h0, busy_a}, {31'h0, run[0]});
      chk("a.done", {31'h0, done_a}, {31'h0, mdone[0]});
      chk("a.pass", {31'h0, pass_a}, {31'h0, mpass[0]});
      chk("b.signature", {16'h0, sig_b}, {16'h0, fold(1, cnt[1])});
      chk("b.count", {24'h0, count_b}, cnt[1]);
      chk("b.busy", {31'h0, busy_b}, {31'h0, run[1]});
      chk("b.done", {31'h0, done_b}, {31'h0, mdone[1]});
      chk("b.pass", {31'h0, pass_b}, {31'h0, mpass[1]});
   end

   task automatic pulse(logic [15:0] v);
      @(negedge clk); result_in = v; ready_in = 1'b1;
      @(negedge clk); ready_in = 1'b0;
   endtask

   task automatic go_a();
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
   endtask

   task automatic run_b(int n, int flip);
      logic [15:0] x;
      x = 16'hACE1;
      @(negedge clk); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      for (int k = 0; k < n; k++) begin
         pulse((k == flip) ? (x ^ 16'h0001) : x);
         x = lfsr_next(x);
      end
   endtask

   initial begin
      reset = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
      ready_in = 1'b0; result_in = 16'h0000;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst.signature", {16'h0, sig_a}, 32'h0);
      chk("rst.count", {24'h0, count_a}, 32'h0);
      chk("rst.flags", {29'h0, busy_a, done_a, pass_a}, 32'h0);

      // edges in IDLE are ignored
      pulse(16'h1234); pulse(16'h5678);
      chk("idle.signature", {16'h0, sig_a}, 32'h0);
      chk("idle.count", {24'h0, count_a}, 32'h0);

      // two-pattern pass
      go_a();
      pulse(16'h0001);
      chk("t2.sig1", {16'h0, sig_a}, 32'h0001);
      pulse(16'h0002);
      chk("t2.sig2", {16'h0, sig_a}, 32'h0000);
      chk("t2.count", {24'h0, count_a}, 32'd2);
      chk("t2.done_pass", {30'h0, done_a, pass_a}, 32'b11);

      // two-pattern fail, restarting from DONE
      go_a();
      chk("t3.restart", {15'h0, done_a, sig_a}, 32'h0);
      pulse(16'h8000);
      chk("t3.sig1", {16'h0, sig_a}, 32'h8000);
      pulse(16'h0000);
      chk("t3.sig2", {16'h0, sig_a}, 32'h002D);
      chk("t3.done_pass", {30'h0, done_a, pass_a}, 32'b10);

      // a long ready level counts once
      go_a();
      @(negedge clk); result_in = 16'h0001; ready_in = 1'b1;
      repeat (10) @(negedge clk);
      ready_in = 1'b0;
      chk("t4.count", {24'h0, count_a}, 32'd1);
      chk("t4.sig", {16'h0, sig_a}, 32'h0001);
      chk("t4.busy", {31'h0, busy_a}, 32'd1);

      // abort beats start; signature held
      @(negedge clk); abort = 1'b1; start_a = 1'b1;
      @(negedge clk); abort = 1'b0; start_a = 1'b0;
      chk("t5.flags", {29'h0, busy_a, done_a, pass_a}, 32'h0);
      chk("t5.sig_held", {16'h0, sig_a}, 32'h0001);
      chk("t5.cnt_held", {24'h0, count_a}, 32'd1);
      go_a();
      chk("t5.reload", {8'h0, count_a, sig_a}, 32'h0);
      chk("t5.busy", {31'h0, busy_a}, 32'd1);
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;

      // start coincident with a ready rise: that edge is not accepted
      @(negedge clk); start_a = 1'b1; result_in = 16'h0077; ready_in = 1'b1;
      @(negedge clk); start_a = 1'b0; ready_in = 1'b0;
      chk("sr.count", {24'h0, count_a}, 32'd0);
      pulse(16'h0005);
      chk("sr.sig", {16'h0, sig_a}, 32'h0005);
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;

      // full 64-pattern sessions
      run_b(64, -1);
      chk("t6.count", {24'h0, count_b}, 32'd64);
      chk("t6.sig", {16'h0, sig_b}, {16'h0, GOLD_B});
      chk("t6.done_pass", {30'h0, done_b, pass_b}, 32'b11);
      run_b(64, 10);
      chk("t6f.done_pass", {30'h0, done_b, pass_b}, 32'b10);
      run_b(30, -1);
      chk("t6r.count30", {24'h0, count_b}, 32'd30);
      @(negedge clk); reset = 1'b0;
      #1;
      chk("t6r.sig", {16'h0, sig_b}, 32'h0);
      chk("t6r.count", {24'h0, count_b}, 32'h0);
      chk("t6r.flags", {29'h0, busy_b, done_b, pass_b}, 32'h0);
      @(negedge clk); reset = 1'b1;
      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
